arcade_memory_ctrl: RTL and testbench

ARCADE_MEMORY_CTRL -- requirements
Module: arcade_memory_ctrl

---
 rtl/arcade_memory_ctrl.sv | 167 ++++++++++++++++
 tb/tb_arcade_memory_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_memory_ctrl.sv
// Arcade program-ROM/colour-RAM controller: download loader, CPU address mapping and read mux.
// Define ARCADE_CRAM_CLEAR_EN to zero the colour RAM after every reset before entering IDLE.
module arcade_memory_ctrl #(
  parameter int          ROM_AW        = 13,
  parameter int          NUM_ROM       = 2,
  parameter int          CRAM_AW       = 11,
  parameter logic [15:0] CRAM_BASE     = 16'h5C00,
  parameter logic [15:0] SCRAMBLE_MASK = 16'h0209
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               dn_download,
  input  logic               dn_wr,
  input  logic [15:0]        dn_addr,
  input  logic [7:0]         dn_data,
  input  logic [15:0]        Addr,
  input  logic               CPU_RW_n,
  input  logic [7:0]         Ram_in,
  input  logic [1:0]         addr_mode,
  input  logic [CRAM_AW-1:0] color_prom_addr,
  output logic [7:0]         Rom_out,
  output logic [7:0]         color_prom_out,
  output logic               rom_ready,
  output logic               cram_busy,
  output logic [16:0]        dn_count
);
  localparam int          RIW          = ROM_AW + $clog2(NUM_ROM);
  localparam int          ROM_DEPTH    = NUM_ROM << ROM_AW;
  localparam int          CRAM_DEPTH   = 1 << CRAM_AW;
  localparam logic [15:0] NUM_ROM16    = 16'(NUM_ROM);
  localparam logic [15:0] DN_CRAM_PAGE = 16'h4000 >> CRAM_AW;
  localparam logic [1:0]  SEL_NONE = 2'd0, SEL_ROM = 2'd1, SEL_CRAM = 2'd2;

  typedef enum logic [1:0] {CLEAR, IDLE, LOADING, DONE} state_t;
`ifdef ARCADE_CRAM_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  logic [7:0] rom_mem  [ROM_DEPTH];
  logic [7:0] cram_mem [CRAM_DEPTH];

  state_t             state_q, state_d;
  logic               rom_ready_q, rom_ready_d;
  logic [16:0]        dn_count_q, dn_count_d;
  logic [CRAM_AW-1:0] clr_addr_q, clr_addr_d;
  logic [1:0]         sel_q, sel_d;
  logic [7:0]         rom_rd_q, cram_rd_q, cprom_q;

  logic [15:0]        maddr, mbank, cram_off, dn_bank;
  logic               dn_accept, dn_in_rom, dn_rom_wr, dn_cram_wr, cpu_cram_wr, clr_wr, cpu_in_cram;
  logic               cram_we;
  logic [CRAM_AW-1:0] cram_wa;
  logic [7:0]         cram_wd;

  always_comb begin
    case (addr_mode)
      2'd1:    maddr = Addr ^ SCRAMBLE_MASK;
      2'd2:    maddr = {Addr[15:10], Addr[8], Addr[9], Addr[7:0]};
      default: maddr = Addr;
    endcase
  end

  always_comb begin
    mbank       = maddr >> ROM_AW;
    cram_off    = maddr - CRAM_BASE;
    cpu_in_cram = (cram_off >> CRAM_AW) == 16'd0;
    dn_bank     = dn_addr >> ROM_AW;
    dn_accept   = dn_download && dn_wr && !Reset;
    dn_in_rom   = dn_bank < NUM_ROM16;
    dn_rom_wr   = dn_accept && dn_in_rom;
    dn_cram_wr  = dn_accept && !dn_in_rom && ((dn_addr >> CRAM_AW) == DN_CRAM_PAGE);
    cpu_cram_wr = !CPU_RW_n && !Reset && cpu_in_cram && !dn_cram_wr &&
                  (state_q == IDLE || state_q == DONE);
`ifdef ARCADE_CRAM_CLEAR_EN
    clr_wr      = (state_q == CLEAR) && !Reset && !dn_cram_wr;
`else
    clr_wr      = 1'b0;
`endif
    // One colour write port: download beats the clear walk, which beats the CPU.
    cram_we = dn_cram_wr || clr_wr || cpu_cram_wr;
    if (dn_cram_wr) begin
      cram_wa = dn_addr[CRAM_AW-1:0];
      cram_wd = dn_data;
    end else if (clr_wr) begin
      cram_wa = clr_addr_q;
      cram_wd = 8'h00;
    end else begin
      cram_wa = cram_off[CRAM_AW-1:0];
      cram_wd = Ram_in;
    end
    if (mbank < NUM_ROM16) sel_d = SEL_ROM;
    else if (cpu_in_cram)  sel_d = SEL_CRAM;
    else                   sel_d = SEL_NONE;
  end

  always_comb begin
    state_d    = state_q;
    dn_count_d = dn_count_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      CLEAR: begin
        if (clr_wr) clr_addr_d = clr_addr_q + CRAM_AW'(1);
        if (dn_download)              state_d = LOADING;
        else if (clr_wr && &clr_addr_q) state_d = IDLE;
      end
      IDLE, DONE: if (dn_download)  state_d = LOADING;
      LOADING:    if (!dn_download) state_d = DONE;
      default:    state_d = IDLE;
    endcase
    // A new download session restarts the byte count, including a byte on the entry cycle.
    if (state_q != LOADING && dn_download)
      dn_count_d = dn_accept ? 17'd1 : 17'd0;
    else if (dn_accept && dn_count_q != 17'h1FFFF)
      dn_count_d = dn_count_q + 17'd1;
    rom_ready_d = (state_d == DONE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= RESET_STATE;
      rom_ready_q <= 1'b0;
      dn_count_q  <= 17'd0;
      clr_addr_q  <= '0;
      sel_q       <= SEL_NONE;
      cprom_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      rom_ready_q <= rom_ready_d;
      dn_count_q  <= dn_count_d;
      clr_addr_q  <= clr_addr_d;
      sel_q       <= sel_d;
      cprom_q     <= cram_mem[color_prom_addr];
    end
  end

  always_ff @(posedge Clock) begin
    if (dn_rom_wr) rom_mem[dn_addr[RIW-1:0]] <= dn_data;
    if (cram_we)   cram_mem[cram_wa] <= cram_wd;
    rom_rd_q  <= rom_mem[maddr[RIW-1:0]];
    cram_rd_q <= cram_mem[cram_off[CRAM_AW-1:0]];
  end

`ifdef ARCADE_CRAM_CLEAR_EN
  logic cram_busy_q;
  always_ff @(posedge Clock) begin
    if (Reset) cram_busy_q <= 1'b1;
    else       cram_busy_q <= (state_d == CLEAR);
  end
  assign cram_busy = cram_busy_q;
`else
  assign cram_busy = 1'b0;
`endif

  always_comb begin
    case (sel_q)
      SEL_ROM:  Rom_out = rom_rd_q;
      SEL_CRAM: Rom_out = cram_rd_q;
      default:  Rom_out = 8'h00;
    endcase
  end

  assign color_prom_out = cprom_q;
  assign rom_ready      = rom_ready_q;
  assign dn_count       = dn_count_q;
endmodule

// File: tb/tb_arcade_memory_ctrl.sv
// Scoreboard bench for arcade_memory_ctrl: reference memory model, queued expectations, negedge monitor.
module tb_arcade_memory_ctrl;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        dn_download = 1'b0, dn_wr = 1'b0;
  logic [15:0] dn_addr = 16'h0;
  logic [7:0]  dn_data = 8'h0;
  logic [15:0] Addr = 16'h0;
  logic        CPU_RW_n = 1'b1;
  logic [7:0]  Ram_in = 8'h0;
  logic [1:0]  addr_mode = 2'd0;
  logic [10:0] color_prom_addr = 11'h0;
  logic [7:0]  Rom_out, color_prom_out;
  logic        rom_ready, cram_busy;
  logic [16:0] dn_count;

  int checks = 0, failures = 0;
  logic [7:0] rom_m  [16384];
  logic [7:0] cram_m [2048];
  logic [7:0] exp_rom_q[$];
  logic [7:0] exp_cp_q[$];
  logic rd_issue = 1'b0, cp_issue = 1'b0, rd_vld = 1'b0, cp_vld = 1'b0;
  logic dl_prev = 1'b0;
  int   mcount = 0;

  always #5 Clock = ~Clock;

  arcade_memory_ctrl dut (
    .Clock(Clock), .Reset(Reset),
    .dn_download(dn_download), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
    .Addr(Addr), .CPU_RW_n(CPU_RW_n), .Ram_in(Ram_in), .addr_mode(addr_mode),
    .color_prom_addr(color_prom_addr),
    .Rom_out(Rom_out), .color_prom_out(color_prom_out),
    .rom_ready(rom_ready), .cram_busy(cram_busy), .dn_count(dn_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] map_addr(input logic [15:0] a, input logic [1:0] m);
    case (m)
      2'd1:    return a ^ 16'h0209;
      2'd2:    return {a[15:10], a[8], a[9], a[7:0]};
      default: return a;
    endcase
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a);
    logic [15:0] off;
    off = a - 16'h5C00;
    if (a < 16'h4000) return rom_m[a[13:0]];
    if (off < 16'd2048) return cram_m[off[10:0]];
    return 8'h00;
  endfunction

  // Applies this cycle's effects to the model, then advances one clock.
  task automatic tick();
    logic [15:0] m, off;
    logic dl_col;
    m = map_addr(Addr, addr_mode);
    if (rd_issue) exp_rom_q.push_back(model_read(m));
    if (cp_issue) exp_cp_q.push_back(cram_m[color_prom_addr]);
    dl_col = 1'b0;
    if (Reset) begin
      mcount  = 0;
      dl_prev = 1'b0;
    end else begin
      if (dn_download && !dl_prev) mcount = 0;
      if (dn_download && dn_wr) begin
        if (mcount < 32'h1FFFF) mcount++;
        if (dn_addr < 16'h4000) rom_m[dn_addr[13:0]] = dn_data;
        else if (dn_addr < 16'h4800) begin
          off = dn_addr - 16'h4000;
          cram_m[off[10:0]] = dn_data;
          dl_col = 1'b1;
        end
      end
      off = m - 16'h5C00;
      if (!CPU_RW_n && !dl_prev && !dl_col && off < 16'd2048) cram_m[off[10:0]] = Ram_in;
      dl_prev = dn_download;
    end
    @(posedge Clock);
    #1;
    rd_issue = 1'b0;
    cp_issue = 1'b0;
    dn_wr    = 1'b0;
    CPU_RW_n = 1'b1;
  endtask

  task automatic dl_byte(input logic [15:0] a, input logic [7:0] d);
    dn_download = 1'b1;
    dn_wr       = 1'b1;
    dn_addr     = a;
    dn_data     = d;
    tick();
  endtask

  task automatic rd(input logic [15:0] a, input logic [1:0] m);
    Addr      = a;
    addr_mode = m;
    rd_issue  = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    int n;
    Reset = 1'b1;
    tick();
    tick();
    chk("rst_rom_ready", rom_ready, 0);
    chk("rst_dn_count", dn_count, 0);
    chk("rst_rom_out", Rom_out, 0);
    chk("rst_color_prom_out", color_prom_out, 0);
    Reset = 1'b0;
`ifdef ARCADE_CRAM_CLEAR_EN
    n = 0;
    for (int g = 0; g < 5000; g++) begin
      @(negedge Clock);
      if (!cram_busy) break;
      n++;
    end
    chk("cram_busy_cycles", n, 2048);
    @(posedge Clock);
    #1;
    foreach (cram_m[i]) cram_m[i] = 8'h00;
    for (int i = 0; i < 2048; i++) begin
      color_prom_addr = 11'(i);
      cp_issue = 1'b1;
      tick();
    end
`else
    n = 0;
    chk("cram_busy_off", cram_busy, n);
`endif
    chk("idle_rom_ready", rom_ready, 0);
  endtask

  always @(posedge Clock) begin
    rd_vld <= rd_issue;
    cp_vld <= cp_issue;
  end

  always @(negedge Clock) begin
    if (rd_vld) begin
      if (exp_rom_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rom_out_queue actual=%0h required=no_read", Rom_out);
      end else chk("rom_out", Rom_out, exp_rom_q.pop_front());
    end
    if (cp_vld) begin
      if (exp_cp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL color_prom_queue actual=%0h required=no_read", color_prom_out);
      end else chk("color_prom_out", color_prom_out, exp_cp_q.pop_front());
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // Download aborted by reset part-way through.
    for (int i = 0; i < 100; i++) dl_byte(16'($urandom_range(0, 16'h3FFF)), 8'($urandom));
    chk("abort_count_100", dn_count, 100);
    Reset = 1'b1;
    tick();
    dn_download = 1'b0;
    do_reset();

    // Full program ROM download with random idle gaps.
    for (int a = 0; a < 16384; a++) begin
      if ($urandom_range(0, 7) == 0) begin
        dn_download = 1'b1;
        tick();
      end
      dl_byte(16'(a), 8'($urandom));
      if (a == 0) chk("restart_count_1", dn_count, 1);
    end
    chk("loading_not_ready", rom_ready, 0);
    chk("count_4000", dn_count, 32'h4000);
    dn_download = 1'b0;
    tick();
    chk("done_rom_ready", rom_ready, 1);
    chk("done_count_4000", dn_count, 32'h4000);

    rd(16'h1234, 2'd0);
    rd(16'h0000, 2'd1);
    rd(16'h0100, 2'd2);
    rd(16'h0209, 2'd3);
    rd(16'h8000, 2'd0);

    // Second session: colour memory plus discarded addresses; CPU write while loading.
    dn_download = 1'b1;
    tick();
    chk("reentry_rom_ready", rom_ready, 0);
    chk("reentry_count_0", dn_count, 0);
    for (int a = 0; a < 2048; a++) begin
      if (a == 100) begin
        CPU_RW_n  = 1'b0;
        Addr      = 16'h5C20;
        addr_mode = 2'd0;
        Ram_in    = 8'hEE;
      end
      dl_byte(16'h4000 + 16'(a), 8'($urandom));
    end
    dl_byte(16'h4800, 8'h11);
    dl_byte(16'h5C00, 8'h22);
    dl_byte(16'hFFFF, 8'h33);
    chk("count_discards", dn_count, 2051);
    dn_download = 1'b0;
    tick();
    chk("done2_rom_ready", rom_ready, 1);
    rd(16'h5C20, 2'd0);
    rd(16'h5C00, 2'd0);

    // CPU colour write, then download write colliding with a CPU write.
    CPU_RW_n  = 1'b0;
    Addr      = 16'h5C10;
    addr_mode = 2'd0;
    Ram_in    = 8'hA5;
    tick();
    rd(16'h5C10, 2'd0);
    dn_download = 1'b1;
    dn_wr       = 1'b1;
    dn_addr     = 16'h4010;
    dn_data     = 8'h3C;
    CPU_RW_n    = 1'b0;
    Addr        = 16'h5C10;
    Ram_in      = 8'h5A;
    tick();
    dn_download = 1'b0;
    tick();
    chk("collide_count_1", dn_count, 1);
    rd(16'h5C10, 2'd0);

    // Random CPU reads/writes and video port reads in DONE.
    for (int i = 0; i < 600; i++) begin
      addr_mode = 2'($urandom);
      case ($urandom_range(0, 2))
        0:       Addr = 16'($urandom_range(0, 16'h3FFF));
        1:       Addr = 16'h5C00 + 16'($urandom_range(0, 2047));
        default: Addr = 16'($urandom);
      endcase
      color_prom_addr = 11'($urandom);
      cp_issue = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        CPU_RW_n = 1'b0;
        Ram_in   = 8'($urandom);
      end else rd_issue = 1'b1;
      tick();
    end
    tick();
    tick();
    chk("random_count_hold", dn_count, mcount);
    chk("random_rom_ready", rom_ready, 1);
    chk("rom_queue_drained", exp_rom_q.size(), 0);
    chk("cp_queue_drained", exp_cp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
